// File: rtl/hlpte_block_scheduler_if.sv
// Bus bundle between the HLPTE block scheduler and its environment.
// master = scheduler side, slave = host/datapath/buffer side.
interface hlpte_block_scheduler_if;
  // load and parameter inputs
  logic        in_valid_data;
  logic        in_valid_param;
  logic [3:0]  index;
  logic        mode;
  logic [4:0]  QP;
  // frame-buffer write port
  logic        fb_we;
  logic [13:0] fb_waddr;
  // datapath command channel
  logic        dp_start;
  logic [3:0]  dp_frame;
  logic [1:0]  dp_blk;
  logic        dp_mode;
  logic [4:0]  dp_qp;
  logic        dp_done;
  // output-buffer read stream
  logic        ob_rd_en;
  logic [9:0]  ob_raddr;
  logic        out_valid;
  // status
  logic        busy;
  logic        err_timeout;
  logic        err_proto;

  modport master (
    input  in_valid_data, in_valid_param, index, mode, QP, dp_done,
    output fb_we, fb_waddr, dp_start, dp_frame, dp_blk, dp_mode, dp_qp,
    output ob_rd_en, ob_raddr, out_valid, busy, err_timeout, err_proto
  );

  modport slave (
    output in_valid_data, in_valid_param, index, mode, QP, dp_done,
    input  fb_we, fb_waddr, dp_start, dp_frame, dp_blk, dp_mode, dp_qp,
    input  ob_rd_en, ob_raddr, out_valid, busy, err_timeout, err_proto
  );
endinterface

// File: rtl/hlpte_block_scheduler.sv
// HLPTE block scheduler: frame-buffer write addressing, parameter burst
// capture, one datapath command per quadrant and a 1024-entry result drain.
module hlpte_block_scheduler #(
  parameter int DP_TIMEOUT = 4096
) (
  input logic                     clk,
  input logic                     rst,
  hlpte_block_scheduler_if.master bus
);

  localparam int FRAME_PIX = 1024;
  localparam int NUM_BLK   = 4;
  localparam int WAIT_W    = $clog2(DP_TIMEOUT);

  localparam logic [9:0]        LAST_RADDR = 10'(FRAME_PIX - 1);
  localparam logic [1:0]        LAST_BLK   = 2'(NUM_BLK - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(DP_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN} state_t;

  state_t              state_r;
  logic [13:0]         pix_cnt_r;
  logic [3:0]          index_r;
  logic [3:0]          mode_r;
  logic [4:0]          qp_r;
  logic [1:0]          bit_cnt_r;
  logic [1:0]          blk_r;
  logic [WAIT_W-1:0]   wait_cnt_r;

  logic [1:0]          bit_pos_s;
  logic [1:0]          nxt_blk_s;
  logic                nxt_mode_s;

  // Mode bits arrive MSB first; quadrant n uses mode_r[3-n].
  always_comb begin
    bit_pos_s  = 2'd3 - bit_cnt_r;
    nxt_blk_s  = blk_r + 2'd1;
    nxt_mode_s = mode_r[2'd3 - nxt_blk_s];
  end

  // Pixel load path: free-running write address, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_r    <= 14'd0;
      bus.fb_we    <= 1'b0;
      bus.fb_waddr <= 14'd0;
    end else begin
      bus.fb_we <= bus.in_valid_data;
      if (bus.in_valid_data) begin
        bus.fb_waddr <= pix_cnt_r;
        pix_cnt_r    <= pix_cnt_r + 14'd1;
      end else begin
        pix_cnt_r    <= pix_cnt_r;
      end
    end
  end

  // Control FSM with all command, stream and status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      index_r         <= 4'd0;
      mode_r          <= 4'd0;
      qp_r            <= 5'd0;
      bit_cnt_r       <= 2'd0;
      blk_r           <= 2'd0;
      wait_cnt_r      <= '0;
      bus.dp_start    <= 1'b0;
      bus.dp_frame    <= 4'd0;
      bus.dp_blk      <= 2'd0;
      bus.dp_mode     <= 1'b0;
      bus.dp_qp       <= 5'd0;
      bus.ob_rd_en    <= 1'b0;
      bus.ob_raddr    <= 10'd0;
      bus.out_valid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_proto   <= 1'b0;
    end else begin
      bus.dp_start    <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_proto   <= 1'b0;
      bus.out_valid   <= bus.ob_rd_en;
      case (state_r)
        IDLE: begin
          if (bus.in_valid_param) begin
            index_r   <= bus.index;
            qp_r      <= bus.QP;
            mode_r[3] <= bus.mode;
            bit_cnt_r <= 2'd1;
            state_r   <= LOAD;
            bus.busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid_param) begin
            mode_r[bit_pos_s] <= bus.mode;
            bit_cnt_r         <= bit_cnt_r + 2'd1;
            if (bit_cnt_r == 2'd3) begin
              // quadrant 0 command goes out the cycle after the last burst beat
              state_r      <= ISSUE;
              blk_r        <= 2'd0;
              bus.dp_start <= 1'b1;
              bus.dp_frame <= index_r;
              bus.dp_blk   <= 2'd0;
              bus.dp_mode  <= mode_r[3];
              bus.dp_qp    <= qp_r;
            end
          end else begin
            bus.err_proto <= 1'b1;
            state_r       <= IDLE;
            bus.busy      <= 1'b0;
          end
        end
        ISSUE: begin
          // dp_done seen during the strobe cycle is deliberately dropped
          wait_cnt_r <= '0;
          state_r    <= WAIT;
        end
        WAIT: begin
          if (bus.dp_done) begin
            if (blk_r == LAST_BLK) begin
              state_r      <= DRAIN;
              bus.ob_rd_en <= 1'b1;
              bus.ob_raddr <= 10'd0;
            end else begin
              blk_r        <= nxt_blk_s;
              state_r      <= ISSUE;
              bus.dp_start <= 1'b1;
              bus.dp_blk   <= nxt_blk_s;
              bus.dp_mode  <= nxt_mode_s;
            end
          end else if (wait_cnt_r == WAIT_LAST) begin
            bus.err_timeout <= 1'b1;
            state_r         <= IDLE;
            bus.busy        <= 1'b0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        DRAIN: begin
          // one tail cycle with rd_en low keeps busy up while the last out_valid is high
          if (bus.ob_rd_en) begin
            if (bus.ob_raddr == LAST_RADDR) begin
              bus.ob_rd_en <= 1'b0;
            end else begin
              bus.ob_raddr <= bus.ob_raddr + 10'd1;
            end
          end else begin
            state_r  <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          bus.busy     <= 1'b0;
          bus.ob_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hlpte_block_scheduler.sv
// Scoreboard bench for hlpte_block_scheduler: stimulus pushes expected
// events (with their expected cycle) into queues, a negedge monitor pops
// and compares whenever the DUT raises a strobe.
module tb_hlpte_block_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hlpte_block_scheduler_if bus ();

  hlpte_block_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct { int c; logic [3:0] frame; logic [1:0] blk; logic mode; logic [4:0] qp; } cmd_t;
  typedef struct { int c; logic [13:0] a; } addr_t;

  cmd_t  cmd_q[$];
  addr_t fb_q[$];
  addr_t rd_q[$];
  int    ov_q[$];
  int    to_q[$];
  int    pe_q[$];

  // monitor: every strobe must match the head of its queue
  always @(negedge clk) begin
    cmd_t  ce;
    addr_t ae;
    int    ci;
    if (bus.fb_we === 1'b1) begin
      if (fb_q.size() == 0) chk("fb_we_unexpected", 64'd1, 64'd0);
      else begin
        ae = fb_q.pop_front();
        chk("fb_waddr", bus.fb_waddr, ae.a);
        chk("fb_we_cycle", cyc, ae.c);
      end
    end
    if (bus.dp_start === 1'b1) begin
      if (cmd_q.size() == 0) chk("dp_start_unexpected", 64'd1, 64'd0);
      else begin
        ce = cmd_q.pop_front();
        chk("dp_start_cycle", cyc, ce.c);
        chk("dp_frame", bus.dp_frame, ce.frame);
        chk("dp_blk", bus.dp_blk, ce.blk);
        chk("dp_mode", bus.dp_mode, ce.mode);
        chk("dp_qp", bus.dp_qp, ce.qp);
      end
    end
    if (bus.ob_rd_en === 1'b1) begin
      if (rd_q.size() == 0) chk("ob_rd_en_unexpected", 64'd1, 64'd0);
      else begin
        ae = rd_q.pop_front();
        chk("ob_raddr", bus.ob_raddr, ae.a);
        chk("ob_rd_en_cycle", cyc, ae.c);
      end
    end
    if (bus.out_valid === 1'b1) begin
      if (ov_q.size() == 0) chk("out_valid_unexpected", 64'd1, 64'd0);
      else begin
        ci = ov_q.pop_front();
        chk("out_valid_cycle", cyc, ci);
      end
    end
    if (bus.err_timeout === 1'b1) begin
      if (to_q.size() == 0) chk("err_timeout_unexpected", 64'd1, 64'd0);
      else begin
        ci = to_q.pop_front();
        chk("err_timeout_cycle", cyc, ci);
      end
    end
    if (bus.err_proto === 1'b1) begin
      if (pe_q.size() == 0) chk("err_proto_unexpected", 64'd1, 64'd0);
      else begin
        ci = pe_q.pop_front();
        chk("err_proto_cycle", cyc, ci);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 4-beat burst; returns the cycle of the last beat
  task automatic burst(input logic [3:0] idx, input logic [4:0] qp, input logic [3:0] m, output int t);
    for (int b = 0; b < 4; b++) begin
      bus.in_valid_param = 1'b1;
      bus.index = (b == 0) ? idx : ~idx;
      bus.QP    = (b == 0) ? qp  : ~qp;
      bus.mode  = m[3 - b];
      t = cyc;
      tick();
    end
    bus.in_valid_param = 1'b0;
  endtask

  // full set: dp_done 10 cycles after each start, then drain (or reset at D+rst_off)
  task automatic run_set(input logic [3:0] idx, input logic [4:0] qp, input logic [3:0] m, input int rst_off);
    int t, s, d, stop;
    addr_t ae;
    burst(idx, qp, m, t);
    s = t + 1;
    d = 0;
    for (int k = 0; k < 4; k++) begin
      cmd_q.push_back('{s, idx, 2'(k), m[3 - k], qp});
      while (cyc < s + 10) tick();
      bus.dp_done = 1'b1;
      d = cyc;
      tick();
      bus.dp_done = 1'b0;
      s = d + 1;
    end
    stop = (rst_off > 0) ? d + rst_off : d + 1025;
    for (int i = 0; i < 1024; i++) begin
      ae.c = d + 1 + i;
      ae.a = 14'(i);
      if (d + 1 + i <= stop) rd_q.push_back(ae);
      if (d + 2 + i <= stop) ov_q.push_back(d + 2 + i);
    end
    while (cyc < stop) begin
      bus.in_valid_param = (cyc == d + 50);
      bus.index = 4'd15;
      tick();
    end
    bus.in_valid_param = 1'b0;
    if (rst_off > 0) begin
      rst = 1'b1;
      tick();
      chk("rst_drain_out_valid", bus.out_valid, 1'b0);
      chk("rst_drain_ob_rd_en", bus.ob_rd_en, 1'b0);
      chk("rst_drain_busy", bus.busy, 1'b0);
      rst = 1'b0;
      tick();
    end else begin
      chk("busy_last_out_valid", {bus.busy, bus.out_valid}, 2'b11);
      tick();
      chk("busy_after_drain", {bus.busy, bus.out_valid}, 2'b00);
    end
  endtask

  initial begin
    int    c0, t;
    addr_t ae;
    logic [13:0] model;
    bus.in_valid_data  = 1'b1;
    bus.in_valid_param = 1'b0;
    bus.index          = 4'd0;
    bus.mode           = 1'b0;
    bus.QP             = 5'd0;
    bus.dp_done        = 1'b0;

    // 1: reset held 3 cycles with in_valid_data high
    tick(); tick(); tick();
    chk("reset_fb_we", bus.fb_we, 1'b0);
    chk("reset_outputs",
        {bus.fb_waddr, bus.dp_start, bus.dp_frame, bus.dp_blk, bus.dp_mode, bus.dp_qp,
         bus.ob_rd_en, bus.ob_raddr, bus.out_valid, bus.busy, bus.err_timeout, bus.err_proto}, 64'd0);
    bus.in_valid_data = 1'b0;
    rst = 1'b0;
    tick();

    // 2: 16385 contiguous writes (wrap), one gap, two more
    model = 14'd0;
    for (int i = 0; i < 16388; i++) begin
      bus.in_valid_data = (i != 16385);
      if (i != 16385) begin
        ae.c = cyc + 1;
        ae.a = model;
        fb_q.push_back(ae);
        model = model + 14'd1;
      end
      tick();
    end
    bus.in_valid_data = 1'b0;
    tick(); tick();

    // 3/4: index 5, QP 17, mode 1,0,1,1 with full drain
    run_set(4'd5, 5'd17, 4'b1011, 0);
    tick(); tick();

    // 5: short burst -> err_proto, then a normal set
    c0 = cyc;
    bus.in_valid_param = 1'b1;
    bus.index = 4'd7;
    bus.QP = 5'd9;
    bus.mode = 1'b1;
    tick(); tick();
    bus.in_valid_param = 1'b0;
    pe_q.push_back(c0 + 3);
    while (cyc < c0 + 4) tick();
    chk("proto_busy", bus.busy, 1'b0);
    run_set(4'd9, 5'd3, 4'b0110, 0);
    tick(); tick();

    // 6a: no dp_done (one in the ISSUE cycle is ignored) -> timeout
    burst(4'd2, 5'd31, 4'b1111, t);
    cmd_q.push_back('{t + 1, 4'd2, 2'd0, 1'b1, 5'd31});
    bus.dp_done = 1'b1;
    tick();
    bus.dp_done = 1'b0;
    to_q.push_back(t + 1 + 4097);
    while (cyc < t + 4100) tick();
    chk("timeout_busy", bus.busy, 1'b0);

    // 6b: reset during DRAIN
    run_set(4'd12, 5'd1, 4'b0001, 100);
    tick(); tick();

    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("fb_q_empty", fb_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("ov_q_empty", ov_q.size(), 0);
    chk("to_q_empty", to_q.size(), 0);
    chk("pe_q_empty", pe_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
